// File: rtl/sched_scoreboard_pkg.sv
// Shared instruction types and helpers for the ID -> RF issue scoreboard.
package sched_scoreboard_pkg;

  localparam int DEF_NUM_ARCH_REGS = 32;
  localparam int ARCH_REG_IDX_W    = $clog2(DEF_NUM_ARCH_REGS);
  localparam int PC_W              = 32;

  typedef struct packed {
    logic                      valid;
    logic [ARCH_REG_IDX_W-1:0] idx;
  } reg_ref_t;

  typedef struct packed {
    reg_ref_t rs1;
    reg_ref_t rs2;
    reg_ref_t rd;
  } decode_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
  } except_t;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    decode_t         decode;
    except_t         except;
  } decoded_instr_t;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    decode_t         decode;
    except_t         except;
  } issued_instr_t;

  typedef struct packed {
    logic                      valid;
    logic [ARCH_REG_IDX_W-1:0] idx;
  } int_arch_reg_wb_t;

  function automatic issued_instr_t compose_issued_instr(
    input logic [PC_W-1:0] pc,
    input decode_t         decode,
    input except_t         except,
    input logic            valid
  );
    issued_instr_t r;
    r.valid  = valid;
    r.pc     = pc;
    r.decode = decode;
    r.except = except;
    return r;
  endfunction

endpackage

// File: rtl/sched_scoreboard_if.sv
// ID/RF/writeback bundle seen by the issue scoreboard; slave = scoreboard side.
interface sched_scoreboard_if
  import sched_scoreboard_pkg::*;
#(
  parameter int NUM_WB = 2
);
  logic                                i_flush;
  logic                                i_stall;
  decoded_instr_t                      i_instr;
  logic                                o_stall;
  issued_instr_t                       o_instr;
  int_arch_reg_wb_t [NUM_WB-1:0]       i_int_reg_wb;
  logic                                o_busy;

  modport master (
    output i_flush, i_stall, i_instr, i_int_reg_wb,
    input  o_stall, o_instr, o_busy
  );

  modport slave (
    input  i_flush, i_stall, i_instr, i_int_reg_wb,
    output o_stall, o_instr, o_busy
  );
endinterface

// File: rtl/sched_scoreboard_pend_ctr.sv
// Per-register pending-write counter: clamp-subtract writebacks, then add the new issue.
module sched_pend_ctr #(
  parameter int PEND_W = 2,
  parameter int HIT_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_inc,
  input  logic [HIT_W-1:0]  i_wbhit,
  output logic [PEND_W-1:0] o_cnt,
  output logic [PEND_W-1:0] o_eff
);
  localparam int W = (PEND_W > HIT_W) ? PEND_W : HIT_W;

  logic [PEND_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]      cnt_x, hit_x;

  assign cnt_x = W'(cnt_q);
  assign hit_x = W'(i_wbhit);
  // Writebacks to an idle register are spurious and must not wrap the count.
  assign o_eff = (cnt_x > hit_x) ? PEND_W'(cnt_x - hit_x) : '0;
  assign cnt_d = o_eff + PEND_W'(i_inc);
  assign o_cnt = cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_clear) begin
      assert (!(i_inc && (&o_eff)));
    end
  end
endmodule

// File: rtl/sched_scoreboard.sv
// In-order issue stage with per-register saturating pending-write counters and WB bypass.
// Optional SCHED_STATS_EN adds free-running issue/hazard counters.
module sched_scoreboard
  import sched_scoreboard_pkg::*;
#(
  parameter int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS,
  parameter int NUM_WB        = 2,
  parameter int PEND_W        = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sched_scoreboard_if.slave sb_if
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0] o_stat_issue,
  output logic [31:0] o_stat_hazard
`endif
);
  localparam int HIT_W = $clog2(NUM_WB + 1);

  logic [PEND_W-1:0] cnt [NUM_ARCH_REGS];
  logic [PEND_W-1:0] eff [NUM_ARCH_REGS];
  logic              rs1_ready, rs2_ready, rd_ready, can_issue;
  issued_instr_t     instr_q;
  decode_t           dec;

  assign dec    = sb_if.i_instr.decode;
  assign cnt[0] = '0;
  assign eff[0] = '0;

  assign rs1_ready = !dec.rs1.valid || (dec.rs1.idx == '0) || (eff[dec.rs1.idx] == '0);
  assign rs2_ready = !dec.rs2.valid || (dec.rs2.idx == '0) || (eff[dec.rs2.idx] == '0);
  assign rd_ready  = !dec.rd.valid  || (dec.rd.idx  == '0) || (eff[dec.rd.idx]  != '1);
  assign can_issue = !sb_if.i_stall && sb_if.i_instr.valid && rs1_ready && rs2_ready && rd_ready;

  assign sb_if.o_stall = sb_if.i_stall ||
                         (sb_if.i_instr.valid && !(rs1_ready && rs2_ready && rd_ready));

  for (genvar r = 1; r < NUM_ARCH_REGS; r++) begin : g_reg
    logic [HIT_W-1:0] hit;
    logic             inc;

    // Ports hitting the same register in one cycle each retire one pending write.
    always_comb begin
      hit = '0;
      for (int p = 0; p < NUM_WB; p++) begin
        if (sb_if.i_int_reg_wb[p].valid &&
            sb_if.i_int_reg_wb[p].idx == ARCH_REG_IDX_W'(r)) begin
          hit = hit + HIT_W'(1);
        end
      end
    end

    assign inc = can_issue && dec.rd.valid && (dec.rd.idx == ARCH_REG_IDX_W'(r));

    sched_pend_ctr #(.PEND_W(PEND_W), .HIT_W(HIT_W)) u_ctr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (sb_if.i_flush),
      .i_inc   (inc),
      .i_wbhit (hit),
      .o_cnt   (cnt[r]),
      .o_eff   (eff[r])
    );
  end

  always_comb begin
    sb_if.o_busy = 1'b0;
    for (int r = 1; r < NUM_ARCH_REGS; r++) begin
      sb_if.o_busy = sb_if.o_busy | (cnt[r] != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || sb_if.i_flush) begin
      instr_q <= '0;
    end else if (!sb_if.i_stall) begin
      instr_q <= compose_issued_instr(sb_if.i_instr.pc, dec, sb_if.i_instr.except, can_issue);
    end
  end

  assign sb_if.o_instr = instr_q;

`ifdef SCHED_STATS_EN
  logic [31:0] stat_issue_q, stat_hazard_q;

  // Statistics survive flushes so they cover the whole run since reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stat_issue_q  <= '0;
      stat_hazard_q <= '0;
    end else begin
      if (can_issue) begin
        stat_issue_q <= stat_issue_q + 32'd1;
      end
      if (sb_if.i_instr.valid && !sb_if.i_stall && !can_issue) begin
        stat_hazard_q <= stat_hazard_q + 32'd1;
      end
    end
  end

  assign o_stat_issue  = stat_issue_q;
  assign o_stat_hazard = stat_hazard_q;
`endif
endmodule
